// File: rtl/icache_refill_ctrl_pkg.sv
// Shared fetch-side definitions: refill FSM states, default line geometry and
// the instruction-access-fault cause code consumed by the trap logic.
package ifetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEAT,
    ST_DRAIN,
    ST_DONE
  } refill_state_e;

  localparam int          LINE_BEATS_DEF = 4;
  localparam int          LINE_BYTES     = LINE_BEATS_DEF * 8;
  localparam int          BEAT_IDX_W     = $clog2(LINE_BEATS_DEF);
  localparam logic [63:0] LINE_OFF_MASK  = 64'(LINE_BYTES - 1);

  // Matches the privileged-spec mcause value for instruction access fault.
  localparam logic [5:0]  CAUSE_IAF      = 6'd1;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Instruction memory read port: one line request, then a stream of 64-bit beats.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_GNT;
  logic              MEM_RVALID;
  logic [63:0]       MEM_RDATA;
  logic              MEM_RERR;

  modport master (
    output MEM_REQ, MEM_ADDR,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA, MEM_RERR
  );

  modport slave (
    input  MEM_REQ, MEM_ADDR,
    output MEM_GNT, MEM_RVALID, MEM_RDATA, MEM_RERR
  );
endinterface

// File: rtl/icache_refill_ctrl_beat_ctr.sv
// Loadable modulo-LINE_BEATS beat index plus a separate count of accepted beats,
// so the last beat is found even when the index starts mid-line.
module refill_beat_ctr #(
  parameter int LINE_BEATS = 4,
  parameter int BW         = $clog2(LINE_BEATS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [BW-1:0] load_idx,
  input  logic          inc,
  output logic [BW-1:0] idx,
  output logic          last
);
  logic [BW-1:0] idx_q, idx_d;
  logic [BW-1:0] num_q, num_d;

  always_comb begin
    idx_d = idx_q;
    num_d = num_q;
    if (load) begin
      idx_d = load_idx;
      num_d = '0;
    end else if (inc) begin
      idx_d = idx_q + BW'(1);
      num_d = num_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      num_q <= '0;
    end else begin
      idx_q <= idx_d;
      num_q <= num_d;
    end
  end

  assign idx  = idx_q;
  assign last = (num_q == BW'(LINE_BEATS - 1));
endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache miss refill controller: one line fill per miss, beat writes, flush and
// bus-error handling. ICACHE_CRITICAL_WORD_FIRST_EN selects critical-word-first fills.
module icache_refill_ctrl
  import ifetch_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int ADDR_W     = 64,
  parameter int BW         = $clog2(LINE_BEATS)
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   FE_PC,
  input  logic                FE_MISS,
  input  logic                FE_FLUSH,
  output logic                IC_STALL,
  output logic                IC_WE,
  output logic [BW-1:0]       IC_WIDX,
  output logic [63:0]         IC_WDATA,
  output logic                IC_LINE_V,
  output logic [ADDR_W-1:0]   IC_LINE_ADDR,
  output logic                F_IAF,
  icache_refill_ctrl_if.master mem
);
  localparam int                OFF_W    = $clog2(LINE_BEATS * 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BEATS * 8 - 1);

  refill_state_e     state_q, state_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              line_v_q, line_v_d;
  logic              iaf_q, iaf_d;

  logic              accept_miss, ic_we;
  logic              ctr_load, ctr_inc, ctr_last;
  logic [BW-1:0]     ctr_load_idx, ctr_idx;
  logic [ADDR_W-1:0] miss_line, miss_req_addr;

  assign accept_miss = (state_q == ST_IDLE) && FE_MISS && !FE_FLUSH;
  assign miss_line   = FE_PC & ~OFF_MASK;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign miss_req_addr = {FE_PC[ADDR_W-1:3], 3'b000};
  assign ctr_load_idx  = FE_PC[OFF_W-1:3];
`else
  assign miss_req_addr = miss_line;
  assign ctr_load_idx  = '0;
`endif

  refill_beat_ctr #(.LINE_BEATS(LINE_BEATS), .BW(BW)) u_beat_ctr (
    .clk      (CLK),
    .rst_n    (reset_n),
    .load     (ctr_load),
    .load_idx (ctr_load_idx),
    .inc      (ctr_inc),
    .idx      (ctr_idx),
    .last     (ctr_last)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    flush_d     = flush_q;
    line_addr_d = line_addr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    line_v_d    = 1'b0;
    iaf_d       = 1'b0;
    ic_we       = 1'b0;
    ctr_load    = 1'b0;
    ctr_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_miss) begin
          line_addr_d = miss_line;
          mem_addr_d  = miss_req_addr;
          mem_req_d   = 1'b1;
          err_d       = 1'b0;
          flush_d     = 1'b0;
          ctr_load    = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (FE_FLUSH) flush_d = 1'b1;
        if (mem.MEM_GNT) begin
          mem_req_d = 1'b0;
          state_d   = (flush_q || FE_FLUSH) ? ST_DRAIN : ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (mem.MEM_RVALID) begin
          ctr_inc = 1'b1;
          if (FE_FLUSH) begin
            // Abandoned fill; a flush on the final beat leaves nothing to drain.
            flush_d = 1'b1;
            state_d = ctr_last ? ST_IDLE : ST_DRAIN;
          end else if (mem.MEM_RERR) begin
            err_d   = 1'b1;
            iaf_d   = ctr_last;
            state_d = ctr_last ? ST_IDLE : ST_DRAIN;
          end else begin
            ic_we    = 1'b1;
            line_v_d = ctr_last;
            state_d  = ctr_last ? ST_DONE : ST_BEAT;
          end
        end else if (FE_FLUSH) begin
          flush_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem.MEM_RVALID) begin
          ctr_inc = 1'b1;
          if (ctr_last) begin
            iaf_d   = err_q && !flush_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      line_addr_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      line_v_q    <= 1'b0;
      iaf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      flush_q     <= flush_d;
      line_addr_q <= line_addr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      line_v_q    <= line_v_d;
      iaf_q       <= iaf_d;
    end
  end

  assign IC_STALL     = accept_miss || (state_q == ST_REQ) ||
                        (state_q == ST_BEAT) || (state_q == ST_DRAIN);
  assign IC_WE        = ic_we;
  assign IC_WIDX      = ctr_idx;
  assign IC_WDATA     = ic_we ? mem.MEM_RDATA : 64'd0;
  assign IC_LINE_V    = line_v_q;
  assign IC_LINE_ADDR = line_addr_q;
  assign F_IAF        = iaf_q;
  assign mem.MEM_REQ  = mem_req_q;
  assign mem.MEM_ADDR = mem_addr_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (LINE_BEATS=4, ADDR_W=64).
module tb_icache_refill_ctrl;
  import ifetch_pkg::*;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] FE_PC = '0;
  logic        FE_MISS = 1'b0;
  logic        FE_FLUSH = 1'b0;
  logic        IC_STALL, IC_WE, IC_LINE_V, F_IAF;
  logic [1:0]  IC_WIDX;
  logic [63:0] IC_WDATA, IC_LINE_ADDR;

  int checks = 0;
  int errors = 0;

  icache_refill_ctrl_if #(.ADDR_W(64)) mem_if ();

  icache_refill_ctrl #(.LINE_BEATS(4), .ADDR_W(64)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .FE_PC        (FE_PC),
    .FE_MISS      (FE_MISS),
    .FE_FLUSH     (FE_FLUSH),
    .IC_STALL     (IC_STALL),
    .IC_WE        (IC_WE),
    .IC_WIDX      (IC_WIDX),
    .IC_WDATA     (IC_WDATA),
    .IC_LINE_V    (IC_LINE_V),
    .IC_LINE_ADDR (IC_LINE_ADDR),
    .F_IAF        (F_IAF),
    .mem          (mem_if)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] exp_req_addr(input logic [63:0] pc);
    return CWF ? (pc & ~64'h7) : (pc & ~64'h1F);
  endfunction

  function automatic logic [1:0] exp_widx(input logic [63:0] pc, input int i);
    int base;
    base = CWF ? int'(pc[4:3]) : 0;
    return 2'((base + i) % 4);
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    mem_if.MEM_GNT = 1'b0; mem_if.MEM_RVALID = 1'b0;
    mem_if.MEM_RDATA = '0; mem_if.MEM_RERR = 1'b0;
    tick(); tick();
    checks++; if (mem_if.MEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_if.MEM_REQ); end
    checks++; if (IC_STALL !== 1'b0 || IC_WE !== 1'b0 || IC_LINE_V !== 1'b0 || F_IAF !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got stall=%b we=%b lv=%b iaf=%b want 0000", IC_STALL, IC_WE, IC_LINE_V, F_IAF); end
    checks++; if (mem_if.MEM_ADDR !== 64'd0 || IC_LINE_ADDR !== 64'd0) begin
      errors++; $display("FAIL reset_addr got mem=%h line=%h want 0", mem_if.MEM_ADDR, IC_LINE_ADDR); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_fill(input logic [63:0] pc);
    logic [63:0] line;
    line = pc & ~64'h1F;
    FE_PC = pc; FE_MISS = 1'b1; #2;
    checks++; if (IC_STALL !== 1'b1) begin errors++; $display("FAIL fill_stall_miss got %b want 1", IC_STALL); end
    checks++; if (mem_if.MEM_REQ !== 1'b0) begin errors++; $display("FAIL fill_req_early got %b want 0", mem_if.MEM_REQ); end
    tick(); FE_MISS = 1'b0; mem_if.MEM_GNT = 1'b1; #2;
    checks++; if (mem_if.MEM_REQ !== 1'b1) begin errors++; $display("FAIL fill_req got %b want 1", mem_if.MEM_REQ); end
    checks++; if (mem_if.MEM_ADDR !== exp_req_addr(pc)) begin
      errors++; $display("FAIL fill_mem_addr got %h want %h", mem_if.MEM_ADDR, exp_req_addr(pc)); end
    tick(); mem_if.MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = pat(i); #2;
      checks++; if (IC_WE !== 1'b1 || IC_STALL !== 1'b1) begin
        errors++; $display("FAIL fill_we[%0d] got we=%b stall=%b want 1 1", i, IC_WE, IC_STALL); end
      checks++; if (IC_WIDX !== exp_widx(pc, i)) begin
        errors++; $display("FAIL fill_widx[%0d] got %0d want %0d", i, IC_WIDX, exp_widx(pc, i)); end
      checks++; if (IC_WDATA !== pat(i)) begin
        errors++; $display("FAIL fill_wdata[%0d] got %h want %h", i, IC_WDATA, pat(i)); end
      checks++; if (IC_LINE_V !== 1'b0) begin errors++; $display("FAIL fill_lv_early[%0d] got %b want 0", i, IC_LINE_V); end
      tick();
    end
    mem_if.MEM_RVALID = 1'b0; #2;
    checks++; if (IC_LINE_V !== 1'b1 || IC_STALL !== 1'b0) begin
      errors++; $display("FAIL fill_done got lv=%b stall=%b want 1 0", IC_LINE_V, IC_STALL); end
    checks++; if (IC_LINE_ADDR !== line) begin
      errors++; $display("FAIL fill_line_addr got %h want %h", IC_LINE_ADDR, line); end
    tick(); #2;
    checks++; if (IC_LINE_V !== 1'b0 || F_IAF !== 1'b0) begin
      errors++; $display("FAIL fill_lv_pulse got lv=%b iaf=%b want 0 0", IC_LINE_V, F_IAF); end
    tick();
  endtask

  task automatic test_gnt_wait();
    FE_PC = 64'h2040; FE_MISS = 1'b1;
    tick(); FE_MISS = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++; if (mem_if.MEM_REQ !== 1'b1 || IC_STALL !== 1'b1) begin
        errors++; $display("FAIL gnt_wait_req[%0d] got req=%b stall=%b want 1 1", c, mem_if.MEM_REQ, IC_STALL); end
      checks++; if (mem_if.MEM_ADDR !== 64'h2040) begin
        errors++; $display("FAIL gnt_wait_addr[%0d] got %h want 2040", c, mem_if.MEM_ADDR); end
      tick();
    end
    mem_if.MEM_GNT = 1'b1;
    tick(); mem_if.MEM_GNT = 1'b0; #2;
    checks++; if (mem_if.MEM_REQ !== 1'b0) begin errors++; $display("FAIL gnt_wait_req_drop got %b want 0", mem_if.MEM_REQ); end
    for (int i = 0; i < 4; i++) begin
      tick(); mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = pat(i);
    end
    tick(); mem_if.MEM_RVALID = 1'b0; #2;
    checks++; if (IC_LINE_V !== 1'b1) begin errors++; $display("FAIL gnt_wait_lv got %b want 1", IC_LINE_V); end
    tick(); tick();
  endtask

  task automatic test_flush_beat1();
    FE_PC = 64'h3000; FE_MISS = 1'b1;
    tick(); FE_MISS = 1'b0; mem_if.MEM_GNT = 1'b1;
    tick(); mem_if.MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = pat(i); FE_FLUSH = (i == 1); #2;
      checks++; if (IC_WE !== (i == 0)) begin
        errors++; $display("FAIL flush_we[%0d] got %b want %b", i, IC_WE, (i == 0)); end
      tick();
    end
    mem_if.MEM_RVALID = 1'b0; FE_FLUSH = 1'b0; #2;
    checks++; if (IC_LINE_V !== 1'b0 || F_IAF !== 1'b0 || IC_STALL !== 1'b0) begin
      errors++; $display("FAIL flush_end got lv=%b iaf=%b stall=%b want 000", IC_LINE_V, F_IAF, IC_STALL); end
    tick(); #2;
    checks++; if (IC_LINE_V !== 1'b0 || F_IAF !== 1'b0) begin
      errors++; $display("FAIL flush_after got lv=%b iaf=%b want 00", IC_LINE_V, F_IAF); end
    FE_PC = 64'h3100; FE_MISS = 1'b1;
    tick(); FE_MISS = 1'b0; #2;
    checks++; if (mem_if.MEM_REQ !== 1'b1) begin errors++; $display("FAIL flush_idle_req got %b want 1", mem_if.MEM_REQ); end
    mem_if.MEM_GNT = 1'b1;
    tick(); mem_if.MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.MEM_RVALID = 1'b1; tick();
    end
    mem_if.MEM_RVALID = 1'b0;
    tick(); tick();
  endtask

  task automatic test_rerr_beat2();
    FE_PC = 64'h4000; FE_MISS = 1'b1;
    tick(); FE_MISS = 1'b0; mem_if.MEM_GNT = 1'b1;
    tick(); mem_if.MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = pat(i); mem_if.MEM_RERR = (i == 2); #2;
      checks++; if (IC_WE !== (i < 2)) begin
        errors++; $display("FAIL rerr_we[%0d] got %b want %b", i, IC_WE, (i < 2)); end
      checks++; if (F_IAF !== 1'b0) begin errors++; $display("FAIL rerr_iaf_early[%0d] got %b want 0", i, F_IAF); end
      tick();
    end
    mem_if.MEM_RVALID = 1'b0; mem_if.MEM_RERR = 1'b0; #2;
    checks++; if (F_IAF !== 1'b1 || IC_LINE_V !== 1'b0 || IC_STALL !== 1'b0) begin
      errors++; $display("FAIL rerr_end got iaf=%b lv=%b stall=%b want 1 0 0", F_IAF, IC_LINE_V, IC_STALL); end
    tick(); #2;
    checks++; if (F_IAF !== 1'b0 || IC_LINE_V !== 1'b0) begin
      errors++; $display("FAIL rerr_pulse got iaf=%b lv=%b want 0 0", F_IAF, IC_LINE_V); end
    tick();
  endtask

  task automatic test_miss_flush_same();
    FE_PC = 64'h7000; FE_MISS = 1'b1; FE_FLUSH = 1'b1; #2;
    checks++; if (IC_STALL !== 1'b0) begin errors++; $display("FAIL missflush_stall got %b want 0", IC_STALL); end
    tick(); FE_MISS = 1'b0; FE_FLUSH = 1'b0; #2;
    checks++; if (mem_if.MEM_REQ !== 1'b0 || IC_STALL !== 1'b0) begin
      errors++; $display("FAIL missflush_req got req=%b stall=%b want 0 0", mem_if.MEM_REQ, IC_STALL); end
    tick();
  endtask

  task automatic test_reset_mid_beat();
    FE_PC = 64'h5000; FE_MISS = 1'b1;
    tick(); FE_MISS = 1'b0; mem_if.MEM_GNT = 1'b1;
    tick(); mem_if.MEM_GNT = 1'b0; mem_if.MEM_RVALID = 1'b1; mem_if.MEM_RDATA = pat(0);
    tick(); mem_if.MEM_RDATA = pat(1);
    reset_n = 1'b0; #1;
    checks++; if (IC_STALL !== 1'b0 || IC_WE !== 1'b0 || IC_LINE_V !== 1'b0 || F_IAF !== 1'b0 || mem_if.MEM_REQ !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl got stall=%b we=%b lv=%b iaf=%b req=%b want 00000",
                         IC_STALL, IC_WE, IC_LINE_V, F_IAF, mem_if.MEM_REQ); end
    checks++; if (IC_WIDX !== 2'd0 || IC_WDATA !== 64'd0 || IC_LINE_ADDR !== 64'd0 || mem_if.MEM_ADDR !== 64'd0) begin
      errors++; $display("FAIL midrst_data got widx=%0d wdata=%h line=%h addr=%h want 0",
                         IC_WIDX, IC_WDATA, IC_LINE_ADDR, mem_if.MEM_ADDR); end
    mem_if.MEM_RVALID = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); #2;
    checks++; if (IC_LINE_V !== 1'b0 || IC_STALL !== 1'b0) begin
      errors++; $display("FAIL midrst_release got lv=%b stall=%b want 0 0", IC_LINE_V, IC_STALL); end
    tick();
    test_basic_fill(64'h6008);
  endtask

  initial begin
    test_reset();
    test_basic_fill(64'h1010);
    test_gnt_wait();
    test_flush_beat1();
    test_rerr_beat2();
    test_miss_flush_same();
    test_reset_mid_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the fetch stage's instruction cache. On an icache miss at the fetch PC, it issues one line-fill request on the instruction memory port and writes the returned beats into the cache data array. It stalls fetch for the duration and marks the line valid when the fill completes. It also handles redirect flushes and bus errors in mid-burst, reporting bus errors to fetch as an instruction access fault.

## Interface
- LINE_BEATS, 4: 64-bit beats per cache line; power of two, at least 2; line = LINE_BEATS*8 bytes.
- ADDR_W, 64: address width.
- CLK  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- FE_PC  in  ADDR_W  current fetch PC.
- FE_MISS  in  1  icache miss at FE_PC this cycle.
- FE_FLUSH  in  1  redirect (branch/jump/trap); the current fill is abandoned.
- IC_STALL  out  1  hold fetch PC and DE latch.
- IC_WE  out  1  write one beat into the cache data array.
- IC_WIDX  out  log2(LINE_BEATS)  beat index within the line for IC_WE.
- IC_WDATA  out  64  beat data.
- IC_LINE_V  out  1  one-cycle pulse: set the tag/valid entry for the line at IC_LINE_ADDR.
- IC_LINE_ADDR  out  ADDR_W  line-aligned address of the fill.
- MEM_REQ  out  1  line read request.
- MEM_ADDR  out  ADDR_W  request address.
- MEM_GNT  in  1  request accepted this cycle.
- MEM_RVALID  in  1  read beat valid.
- MEM_RDATA  in  64  read beat.
- MEM_RERR  in  1  bus error on this beat.
- F_IAF  out  1  one-cycle instruction access fault pulse to fetch.

## Operation
- States: IDLE, REQ, BEAT, DRAIN, DONE.
- IDLE:
  - FE_MISS && !FE_FLUSH: latch IC_LINE_ADDR = FE_PC with the low log2(LINE_BEATS*8) bits cleared; go to REQ.
  - FE_MISS && FE_FLUSH in the same cycle: flush wins and no request is made.
- REQ: MEM_REQ=1. Once asserted, MEM_REQ and MEM_ADDR stay stable until MEM_GNT. On MEM_GNT, go to BEAT, or to DRAIN if a flush was recorded.
- BEAT:
  - Each MEM_RVALID: IC_WE=1, IC_WIDX = beat counter, IC_WDATA = MEM_RDATA; counter increments modulo LINE_BEATS.
  - After LINE_BEATS beats, go to DONE.
  - MEM_RERR on any beat: no IC_WE for that beat; set the sticky err flag; go to DRAIN.
- DRAIN: absorb the remaining beats with IC_WE=0. After the last beat, go to IDLE. F_IAF pulses in that transition cycle if err is set and no flush was recorded.
- DONE: IC_LINE_V=1 for one cycle; then IDLE.
- FE_FLUSH handling:
  - In REQ, the flush is recorded.
  - In BEAT, go to DRAIN; a flush in the same cycle as a beat suppresses that beat's IC_WE.
  - A flush in DRAIN or DONE has no effect; a completed line is still validated.
- IC_STALL = (IDLE && FE_MISS && !FE_FLUSH) || state in {REQ, BEAT, DRAIN}. It is combinational. It is low in DONE.
- MEM_ADDR = IC_LINE_ADDR, unless the configuration macro is defined (see Configuration).
- Reset:
  - All outputs 0; state IDLE; counter, err and flush flags cleared.
  - Reset mid-fill abandons the fill, and no line is validated.

## Timing
- Miss seen at cycle t: MEM_REQ=1 at t+1.
- MEM_GNT at cycle g: the first beat is accepted no earlier than g+1.
- Beat writes: IC_WE is asserted in the same cycle as MEM_RVALID (combinational path from MEM_RVALID to IC_WE).
- Last beat at cycle b: IC_LINE_V=1 and IC_STALL=0 at b+1; IDLE at b+2. A new miss is accepted at b+2.
- Minimum miss-to-unstall with grant at t+1 and back-to-back beats: t+2+LINE_BEATS.
- Registered outputs: MEM_REQ, MEM_ADDR, IC_LINE_V, F_IAF, IC_LINE_ADDR.

## Configuration
- ICACHE_CRITICAL_WORD_FIRST_EN defined:
  - MEM_ADDR = FE_PC aligned to 8 bytes.
  - The beat counter starts at the missed beat index and wraps modulo LINE_BEATS.
  - IC_WIDX follows the wrapped sequence.
- Undefined: the counter starts at 0 and MEM_ADDR is line-aligned.
- Beat count, DONE and IC_LINE_V behaviour are identical in both builds.

## Structure
- Shared package ifetch_pkg holds:
  - the state enum;
  - LINE_BYTES, BEAT_IDX_W and the line-offset mask;
  - the IAF cause constant used by the trap logic.
- One sub-module, refill_beat_ctr: a loadable modulo-LINE_BEATS counter that also detects the last beat.

## Test plan
- Miss at FE_PC=0x1010, LINE_BEATS=4, grant immediate, 4 back-to-back beats:
  - MEM_ADDR=0x1000;
  - IC_WIDX 0,1,2,3;
  - IC_LINE_V with IC_LINE_ADDR=0x1000 one cycle after beat 3;
  - IC_STALL low in the same cycle.
- Same miss with ICACHE_CRITICAL_WORD_FIRST_EN: MEM_ADDR=0x1010; IC_WIDX 2,3,0,1.
- MEM_GNT held low 5 cycles: MEM_REQ and MEM_ADDR stay stable for all 5 cycles; IC_STALL stays high.
- FE_FLUSH during beat 1: no IC_WE for beats 1-3, no IC_LINE_V, no F_IAF; IDLE after beat 3.
- MEM_RERR on beat 2: IC_WE only for beats 0-1; F_IAF pulses once after beat 3; no IC_LINE_V.
- reset_n low mid-BEAT: all outputs 0 immediately; after release, a fresh miss is handled normally.
